// File: rtl/input_conditioner.sv
// Input conditioner: each channel gets a 2-flop synchronizer, a debouncer,
// edge detection and a toggle bit. A registered mode select picks which view drives b.

module ic_lane #(
  parameter int DEB_MAX = 50000,
  parameter int DEB_W   = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic clr,
  output logic s2,
  output logic st,
  output logic rise,
  output logic chg,
  output logic tg
);
  localparam logic [DEB_W-1:0] CNT_TOP = DEB_W'(DEB_MAX - 1);

  logic             s1;
  logic             st_d;
  logic [DEB_W-1:0] cnt;

  assign rise = st & ~st_d;
  assign chg  = st ^ st_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      st   <= 1'b0;
      st_d <= 1'b0;
      tg   <= 1'b0;
      cnt  <= '0;
    end else begin
      s1   <= a;
      s2   <= s1;
      st_d <= st;
      // Any return to the accepted level discards the partial count.
      if (s2 == st) begin
        cnt <= '0;
      end else if (cnt == CNT_TOP) begin
        st  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + DEB_W'(1);
      end
      if (clr)       tg <= 1'b0;
      else if (rise) tg <= ~tg;
    end
  end
endmodule

module input_conditioner #(
  parameter int N_CH    = 4,
  parameter int DEB_MAX = 50000,
  parameter int DEB_W   = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] a,
  input  logic [1:0]      mode,
  input  logic            clr,
  output logic [N_CH-1:0] b,
  output logic [N_CH-1:0] chg
);
  logic [1:0]      mode_q;
  logic [N_CH-1:0] s2, st, rise, tg;

  always_ff @(posedge clk) begin
    if (!rst_n) mode_q <= 2'b00;
    else        mode_q <= mode;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    ic_lane #(
      .DEB_MAX(DEB_MAX),
      .DEB_W  (DEB_W)
    ) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .a    (a[i]),
      .clr  (clr),
      .s2   (s2[i]),
      .st   (st[i]),
      .rise (rise[i]),
      .chg  (chg[i]),
      .tg   (tg[i])
    );
  end

  // Mode only steers the output; lane state runs regardless.
  always_comb begin
    b = '0;
    case (mode_q)
      2'b00:   b = s2;
      2'b01:   b = st;
      2'b10:   b = rise;
      default: b = tg;
    endcase
  end
endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with N_CH=4, DEB_MAX=4; expected values
// are hand-derived edge counts relative to when a is changed.

module tb_input_conditioner;
  localparam int N_CH    = 4;
  localparam int DEB_MAX = 4;
  localparam int DEB_W   = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N_CH-1:0] a;
  logic [1:0]      mode;
  logic            clr;
  logic [N_CH-1:0] b;
  logic [N_CH-1:0] chg;

  int n_vec = 0;
  int n_bad = 0;

  input_conditioner #(
    .N_CH   (N_CH),
    .DEB_MAX(DEB_MAX),
    .DEB_W  (DEB_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .mode (mode),
    .clr  (clr),
    .b    (b),
    .chg  (chg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after an edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    a = '0;
    repeat (10) tick();
  endtask

  // Hold a[2] high for 8 cycles then low for 8: one accepted rise and fall.
  task automatic press2();
    a[2] = 1'b1;
    repeat (8) tick();
    a[2] = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    a     = '0;
    mode  = 2'b00;
    clr   = 1'b0;
    repeat (2) tick();
    chk("rst_b", 32'(b), 32'h0);
    chk("rst_chg", 32'(chg), 32'h0);

    // Release with a low: nothing may pulse.
    rst_n = 1'b1;
    mode  = 2'b01;
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk("rel_b", 32'(b), 32'h0);
      chk("rel_chg", 32'(chg), 32'h0);
    end

    // Debounced level on ch0: accepted at edge 6, chg for one cycle.
    a[0] = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk("deb0_b", 32'(b), (e >= 6) ? 32'h1 : 32'h0);
      chk("deb0_chg", 32'(chg), (e == 6) ? 32'h1 : 32'h0);
    end
    settle();
    chk("deb0_clear", 32'(b), 32'h0);

    // ch1 glitch of 3 s2 cycles is rejected.
    a[1] = 1'b1;
    repeat (3) tick();
    a[1] = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      tick();
      chk("glitch_b", 32'(b), 32'h0);
      chk("glitch_chg", 32'(chg), 32'h0);
    end

    // ch1 pulse of exactly 4 s2 cycles is accepted, then released.
    a[1] = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 4) a[1] = 1'b0;
      chk("exact_b", 32'(b), (e >= 6 && e <= 9) ? 32'h2 : 32'h0);
      chk("exact_chg", 32'(chg), (e == 6 || e == 10) ? 32'h2 : 32'h0);
    end
    settle();

    // Toggle mode on ch2; clear earlier toggle state first.
    mode = 2'b11;
    clr  = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    chk("tg_clr", 32'(b), 32'h0);
    press2();
    chk("tg_p1", 32'(b), 32'h4);
    press2();
    chk("tg_p2", 32'(b), 32'h0);
    press2();
    chk("tg_p3", 32'(b), 32'h4);

    // 4th press: clr on the rise edge.
    a[2] = 1'b1;
    repeat (6) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("tg_p4_clr", 32'(b), 32'h0);
    a[2] = 1'b0;
    repeat (8) tick();

    // 5th press: tg is 0, so only clr priority keeps it 0.
    a[2] = 1'b1;
    repeat (6) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("tg_p5_prio", 32'(b), 32'h0);
    settle();

    // Rise mode: ch0 and ch3 together.
    mode = 2'b10;
    tick();
    chk("rise_idle", 32'(b), 32'h0);
    a = 4'b1001;
    for (int e = 1; e <= 9; e++) begin
      tick();
      chk("rise_b", 32'(b), (e == 6) ? 32'h9 : 32'h0);
    end
    a = 4'b0000;
    for (int e = 1; e <= 9; e++) begin
      tick();
      chk("fall_b", 32'(b), 32'h0);
      chk("fall_chg", 32'(chg), (e == 6) ? 32'h9 : 32'h0);
    end
    settle();

    // Reset mid-debounce on held ch0.
    mode = 2'b01;
    tick();
    a[0] = 1'b1;
    repeat (3) tick();
    rst_n = 1'b0;
    for (int e = 1; e <= 2; e++) begin
      tick();
      chk("mid_rst_b", 32'(b), 32'h0);
      chk("mid_rst_chg", 32'(chg), 32'h0);
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk("post_rst_b", 32'(b), (e >= 6) ? 32'h1 : 32'h0);
      chk("post_rst_chg", 32'(chg), (e == 6) ? 32'h1 : 32'h0);
    end
    settle();

    // Mode switch 01 -> 00 mid-debounce on ch3, then back.
    a[3] = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 3) chk("msw_pre", 32'(b), 32'h0);
      if (e == 3) mode = 2'b00;
      if (e == 4) chk("msw_s2", 32'(b), 32'h8);
      if (e == 6) mode = 2'b01;
      if (e >= 4 && e <= 8) chk("msw_chg", 32'(chg), (e == 6) ? 32'h8 : 32'h0);
      if (e == 7) chk("msw_st", 32'(b), 32'h8);
    end
    settle();
    chk("final_b", 32'(b), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
